// File: rtl/rom_pkg.sv
// Shared types, defaults and helpers for the ROM read arbiter.
// Grant statistics (ROM_ARB_STATS_EN) use GNT_CNT_W and sat_inc from here.
package rom_pkg;
    localparam int ROM_ADDR_W = 3;
    localparam int ROM_DATA_W = 4;
    localparam int GNT_CNT_W  = 8;

    typedef logic [0:0] state_t;
    localparam state_t IDLE  = 1'b0;
    localparam state_t BURST = 1'b1;

    typedef logic req_id_t;

    function automatic logic [GNT_CNT_W-1:0] sat_inc(input logic [GNT_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: combinational winner from the two requests and
// the previous winner; the caller owns the last-winner register.
module rr_arb2
    import rom_pkg::*;
(
    input  logic    i_req0,
    input  logic    i_req1,
    input  req_id_t i_last_winner,
    output req_id_t o_winner,
    output logic    o_any
);
    // On a tie the requester that did not win last time goes next.
    always_comb begin
        o_winner = 1'b0;
        if (i_req0 && i_req1) begin
            o_winner = ~i_last_winner;
        end else if (i_req1) begin
            o_winner = 1'b1;
        end
    end

    assign o_any = i_req0 | i_req1;
endmodule

// File: rtl/rom_read_arbiter.sv
// Round-robin burst reader sharing one combinational ROM between two requesters.
// Define ROM_ARB_STATS_EN to add saturating per-requester grant counters.
module rom_read_arbiter
    import rom_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = ROM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] len0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] len1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_id,
    output logic              rd_last,
`ifdef ROM_ARB_STATS_EN
    output logic [GNT_CNT_W-1:0] gnt_cnt0,
    output logic [GNT_CNT_W-1:0] gnt_cnt1,
`endif
    output logic              busy
);
    state_t            r_state;
    req_id_t           r_owner;
    req_id_t           r_last_winner;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [ADDR_W-1:0] r_beats_left;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_id;
    logic              r_rd_last;

    req_id_t w_winner;
    logic    w_any;
    logic    w_take;

    rr_arb2 u_arb (
        .i_req0        (req0),
        .i_req1        (req1),
        .i_last_winner (r_last_winner),
        .o_winner      (w_winner),
        .o_any         (w_any)
    );

    assign w_take = (r_state == IDLE) && w_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_owner       <= 1'b0;
            r_last_winner <= 1'b1;
            r_cur_addr    <= '0;
            r_beats_left  <= '0;
            r_gnt0        <= 1'b0;
            r_gnt1        <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_rd_data     <= '0;
            r_rd_id       <= 1'b0;
            r_rd_last     <= 1'b0;
        end else begin
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_rd_valid <= 1'b0;
            if (r_state == IDLE) begin
                if (w_take) begin
                    r_state       <= BURST;
                    r_owner       <= w_winner;
                    r_last_winner <= w_winner;
                    r_cur_addr    <= w_winner ? addr1 : addr0;
                    r_beats_left  <= w_winner ? len1 : len0;
                    r_gnt0        <= ~w_winner;
                    r_gnt1        <= w_winner;
                end
            end else begin
                // One beat per cycle; the address counter wraps at the ROM depth.
                r_rd_data    <= rom_data;
                r_rd_valid   <= 1'b1;
                r_rd_id      <= r_owner;
                r_rd_last    <= (r_beats_left == '0);
                r_cur_addr   <= r_cur_addr + 1'b1;
                r_beats_left <= r_beats_left - 1'b1;
                if (r_beats_left == '0) begin
                    r_state <= IDLE;
                end
            end
        end
    end

`ifdef ROM_ARB_STATS_EN
    logic [1:0] w_gnt_evt;
    assign w_gnt_evt[0] = w_take & ~w_winner;
    assign w_gnt_evt[1] = w_take & w_winner;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [GNT_CNT_W-1:0] r_cnt;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_gnt_evt[gi]) begin
                    r_cnt <= sat_inc(r_cnt);
                end
            end
        end
    endgenerate

    assign gnt_cnt0 = g_cnt[0].r_cnt;
    assign gnt_cnt1 = g_cnt[1].r_cnt;
`endif

    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign rom_addr = (r_state == BURST) ? r_cur_addr : '0;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign rd_id    = r_rd_id;
    assign rd_last  = r_rd_last;
    assign busy     = (r_state == BURST);
endmodule

// File: tb/tb_rom_read_arbiter.sv
// Self-checking bench for rom_read_arbiter: a cycle schedule derived from the
// burst rules predicts every output; ROM_ARB_STATS_EN also checks the counters.
module tb_rom_read_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [2:0] addr0, len0, addr1, len1;
    logic       gnt0, gnt1;
    logic [2:0] rom_addr;
    logic [3:0] rom_data;
    logic       rd_valid;
    logic [3:0] rd_data;
    logic       rd_id;
    logic       rd_last;
    logic       busy;
`ifdef ROM_ARB_STATS_EN
    logic [7:0] gnt_cnt0, gnt_cnt1;
`endif

    logic [3:0] rom [8];
    assign rom_data = rom[rom_addr];

    int checks = 0;
    int errors = 0;
    bit m_last;
    int m_cnt0, m_cnt1;

    rom_read_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .len0(len0),
        .req1(req1), .addr1(addr1), .len1(len1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_id(rd_id), .rd_last(rd_last),
`ifdef ROM_ARB_STATS_EN
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serve one or two bursts from IDLE and compare every cycle to the schedule.
    task automatic run_pair(input bit r0, input bit r1, input logic [2:0] a0, input logic [2:0] l0,
                            input logic [2:0] a1, input logic [2:0] l1, input string tag);
        int n, kend;
        int s [2];
        bit who [2];
        logic [2:0] aa [2];
        logic [2:0] ll [2];
        bit e_g0, e_g1, e_busy, e_v, e_id, e_last;
        logic [2:0] e_ra;
        logic [3:0] e_d;
        who[0] = (r0 && r1) ? ~m_last : r1;
        who[1] = ~who[0];
        n = (r0 && r1) ? 2 : 1;
        for (int b = 0; b < 2; b++) begin
            aa[b] = who[b] ? a1 : a0;
            ll[b] = who[b] ? l1 : l0;
        end
        s[0] = 1;
        s[1] = 3 + int'(ll[0]);
        kend = s[n-1] + int'(ll[n-1]) + 2;
        m_last = who[n-1];
        for (int b = 0; b < n; b++) begin
            if (who[b]) m_cnt1++; else m_cnt0++;
        end
        $display("run %s: req=%0d%0d first=%0d addr=%0d len=%0d", tag, r1, r0, who[0], aa[0], ll[0]);
        req0 = r0; addr0 = a0; len0 = l0;
        req1 = r1; addr1 = a1; len1 = l1;
        for (int k = 1; k <= kend; k++) begin
            tick();
            e_g0 = 0; e_g1 = 0; e_busy = 0; e_ra = '0; e_v = 0; e_d = '0; e_id = 0; e_last = 0;
            for (int b = 0; b < n; b++) begin
                if (k == s[b]) begin
                    if (who[b]) e_g1 = 1; else e_g0 = 1;
                end
                if (k >= s[b] && k <= s[b] + int'(ll[b])) begin
                    e_busy = 1;
                    e_ra = aa[b] + 3'(k - s[b]);
                end
                if (k >= s[b] + 1 && k <= s[b] + 1 + int'(ll[b])) begin
                    e_v = 1;
                    e_d = rom[aa[b] + 3'(k - s[b] - 1)];
                    e_id = who[b];
                    e_last = (k == s[b] + 1 + int'(ll[b]));
                end
            end
            checks++;
            if (gnt0 !== e_g0 || gnt1 !== e_g1) begin
                errors++;
                $display("FAIL %s gnt k=%0d got %b%b exp %b%b", tag, k, gnt1, gnt0, e_g1, e_g0);
            end
            checks++;
            if (busy !== e_busy || rom_addr !== e_ra) begin
                errors++;
                $display("FAIL %s busy/rom_addr k=%0d got %b/%0d exp %b/%0d", tag, k, busy, rom_addr, e_busy, e_ra);
            end
            checks++;
            if (rd_valid !== e_v) begin
                errors++;
                $display("FAIL %s rd_valid k=%0d got %b exp %b", tag, k, rd_valid, e_v);
            end
            if (e_v) begin
                checks++;
                if (rd_data !== e_d || rd_id !== e_id || rd_last !== e_last) begin
                    errors++;
                    $display("FAIL %s beat k=%0d got d=%h id=%b last=%b exp d=%h id=%b last=%b",
                             tag, k, rd_data, rd_id, rd_last, e_d, e_id, e_last);
                end
            end
            // Drop the granted request and scramble its fields: no effect mid-burst.
            for (int b = 0; b < n; b++) begin
                if (k == s[b]) begin
                    if (who[b]) begin
                        req1 = 0; addr1 = 3'($urandom); len1 = 3'($urandom);
                    end else begin
                        req0 = 0; addr0 = 3'($urandom); len0 = 3'($urandom);
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1; req0 = 0; req1 = 0;
        tick(); tick();
        rst = 0;
        m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
    endtask

    task automatic test_reset();
        rst = 1; req0 = 1; addr0 = 3'd5; len0 = 3'd0; req1 = 0; addr1 = 0; len1 = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({gnt0, gnt1, rd_valid, rd_data, rd_id, rd_last, busy, rom_addr} !== 14'd0) begin
                errors++;
                $display("FAIL reset outputs cyc=%0d got g=%b%b v=%b d=%h id=%b l=%b busy=%b ra=%0d exp all 0",
                         i, gnt1, gnt0, rd_valid, rd_data, rd_id, rd_last, busy, rom_addr);
            end
        end
        rst = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
`ifdef ROM_ARB_STATS_EN
        checks++;
        if (gnt_cnt0 !== 8'd0 || gnt_cnt1 !== 8'd0) begin
            errors++;
            $display("FAIL reset gnt_cnt got %0d/%0d exp 0/0", gnt_cnt0, gnt_cnt1);
        end
`endif
        tick();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || busy !== 1'b1 || rom_addr !== 3'd5) begin
            errors++;
            $display("FAIL reset first_gnt got g0=%b g1=%b busy=%b ra=%0d exp 1 0 1 5", gnt0, gnt1, busy, rom_addr);
        end
        req0 = 0;
        tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== rom[5] || rd_id !== 1'b0 || rd_last !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset first_beat got v=%b d=%h id=%b l=%b busy=%b exp 1 %h 0 1 0",
                     rd_valid, rd_data, rd_id, rd_last, busy, rom[5]);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset idle_after got rd_valid=%b exp 0", rd_valid);
        end
        m_last = 0; m_cnt0 = 1;
        $display("run reset: single beat from addr 5 after release");
    endtask

    task automatic test_alternate();
        bit first, w;
        logic [2:0] a0, a1;
        first = ~m_last;
        a0 = 3'($urandom); a1 = 3'($urandom);
        req0 = 1; req1 = 1; addr0 = a0; addr1 = a1; len0 = 0; len1 = 0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k % 2 == 1 && k <= 7) begin
                w = first ^ bit'(((k - 1) / 2) % 2);
                checks++;
                if (gnt0 !== ~w || gnt1 !== w || busy !== 1'b1 || rom_addr !== (w ? a1 : a0)) begin
                    errors++;
                    $display("FAIL alternate gnt k=%0d got g=%b%b busy=%b ra=%0d exp winner %0d", k, gnt1, gnt0, busy, rom_addr, w);
                end
            end
            checks++;
            if (rd_valid !== (k % 2 == 0 && k <= 8)) begin
                errors++;
                $display("FAIL alternate rd_valid k=%0d got %b exp %b", k, rd_valid, (k % 2 == 0 && k <= 8));
            end
            if (k % 2 == 0 && k <= 8) begin
                w = first ^ bit'(((k - 2) / 2) % 2);
                checks++;
                if (rd_id !== w || rd_data !== rom[w ? a1 : a0] || rd_last !== 1'b1) begin
                    errors++;
                    $display("FAIL alternate beat k=%0d got id=%b d=%h l=%b exp id=%b d=%h l=1", k, rd_id, rd_data, rd_last, w, rom[w ? a1 : a0]);
                end
            end
            if (k == 7) begin
                req0 = 0; req1 = 0;
            end
        end
        m_last = ~first; m_cnt0 += 2; m_cnt1 += 2;
        $display("run alternate: 4 single-beat bursts, first winner %0d", first);
    endtask

    task automatic test_random();
        bit r0, r1;
        for (int i = 0; i < 40; i++) begin
            r0 = 1'($urandom); r1 = 1'($urandom);
            if (!r0 && !r1) r0 = 1;
            run_pair(r0, r1, 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), "random");
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [2:0] a;
        a = 3'($urandom);
        req0 = 1; addr0 = a; len0 = 3'd7; req1 = 0;
        tick();
        checks++;
        if (gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL midrst gnt0 got %b exp 1", gnt0);
        end
        req0 = 0;
        for (int k = 2; k <= 4; k++) begin
            tick();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== rom[a + 3'(k - 2)]) begin
                errors++;
                $display("FAIL midrst beat k=%0d got v=%b d=%h exp 1 %h", k, rd_valid, rd_data, rom[a + 3'(k - 2)]);
            end
        end
        rst = 1;
        tick();
        checks++;
        if (rd_valid !== 1'b0 || busy !== 1'b0 || rom_addr !== 3'd0 || gnt0 !== 1'b0) begin
            errors++;
            $display("FAIL midrst after_rst got v=%b busy=%b ra=%0d g0=%b exp 0 0 0 0", rd_valid, busy, rom_addr, gnt0);
        end
        rst = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
        $display("run midrst: reset during beat 3 of 8 from addr %0d", a);
        run_pair(0, 1, 3'd0, 3'd0, 3'($urandom), 3'($urandom), "post_rst");
    endtask

`ifdef ROM_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 3; i++) run_pair(1, 0, 3'($urandom), 3'd0, 3'd0, 3'd0, "stats0");
        run_pair(0, 1, 3'd0, 3'd0, 3'($urandom), 3'd1, "stats1");
        checks++;
        if (gnt_cnt0 !== 8'(m_cnt0) || gnt_cnt1 !== 8'(m_cnt1)) begin
            errors++;
            $display("FAIL stats small got %0d/%0d exp %0d/%0d", gnt_cnt0, gnt_cnt1, m_cnt0, m_cnt1);
        end
        for (int i = 0; i < 300; i++) run_pair(1, 0, 3'($urandom), 3'd0, 3'd0, 3'd0, "stats_sat");
        checks++;
        if (gnt_cnt0 !== 8'((m_cnt0 > 255) ? 255 : m_cnt0) || gnt_cnt1 !== 8'(m_cnt1)) begin
            errors++;
            $display("FAIL stats saturate got %0d/%0d exp %0d/%0d", gnt_cnt0, gnt_cnt1,
                     (m_cnt0 > 255) ? 255 : m_cnt0, m_cnt1);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 8; i++) rom[i] = 4'($urandom);
        test_reset();
        run_pair(1, 0, 3'd2, 3'd3, 3'd0, 3'd0, "single");
        run_pair(0, 1, 3'd0, 3'd0, 3'd6, 3'd3, "wrap");
        test_alternate();
        test_random();
        test_reset_mid_burst();
`ifdef ROM_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
